// File: rtl/sdram_arbiter_if.sv
// Bus bundle between four requesters, the SDRAM controller request port and
// the returned read-data stream.
//   p_*      : per-port request side (addr/data/req/wr in, ack/rvalid/rdata out)
//   req_*    : single request channel toward the controller
//   mem_*    : returned read words tagged with the port id
//   busy/err : arbiter status
// Modport slave is the arbiter's view; master is the surrounding system's view.
interface sdram_arbiter_if #(
    parameter int unsigned AN = 24,
    parameter int unsigned DN = 16
);
    logic [3:0][AN-1:0] p_addr;
    logic [3:0][DN-1:0] p_data;
    logic [3:0]         p_req;
    logic [3:0]         p_wr;
    logic [3:0]         p_ack;
    logic [3:0]         p_rvalid;
    logic [DN-1:0]      p_rdata;
    logic [AN-1:0]      req_addr;
    logic [DN-1:0]      req_data;
    logic [1:0]         req_id;
    logic               req;
    logic               req_wr;
    logic               req_ack;
    logic [DN-1:0]      mem_data;
    logic [1:0]         mem_id;
    logic               mem_valid;
    logic               busy;
    logic               err;

    modport slave (
        input  p_addr, p_data, p_req, p_wr, req_ack, mem_data, mem_id, mem_valid,
        output p_ack, p_rvalid, p_rdata, req_addr, req_data, req_id, req, req_wr,
               busy, err
    );

    modport master (
        output p_addr, p_data, p_req, p_wr, req_ack, mem_data, mem_id, mem_valid,
        input  p_ack, p_rvalid, p_rdata, req_addr, req_data, req_id, req, req_wr,
               busy, err
    );
endinterface

// File: rtl/sdram_arbiter.sv
// Four-port arbiter sharing one SDRAM controller request channel.
// Accepted requests are tagged with the port number as id; returned read words
// are routed back to the owning port, and outstanding read bursts are counted
// per port so no port can hold more than MAXRD reads in flight.
// Ports:
//   clkSYS : system clock, rising edge
//   reset  : synchronous active-high reset
//   bus    : sdram_arbiter_if.slave (requesters, controller, read return, status)
module sdram_arbiter #(
    parameter int unsigned AN    = 24,
    parameter int unsigned DN    = 16,
    parameter int unsigned BURST = 8,
    parameter int unsigned MAXRD = 2,
    parameter bit          PRIO0 = 1'b1
) (
    input logic            clkSYS,
    input logic            reset,
    sdram_arbiter_if.slave bus
);
    localparam int unsigned WW    = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [WW-1:0] WLAST = WW'(BURST - 1);
    localparam logic [2:0]    MAXC  = 3'(MAXRD);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t              state_q;
    logic [1:0]          rr_ptr_q;
    logic [1:0]          grant_q;
    logic                req_q;
    logic                req_wr_q;
    logic [AN-1:0]       req_addr_q;
    logic [DN-1:0]       req_data_q;
    logic [3:0]          p_rvalid_q;
    logic [DN-1:0]       p_rdata_q;
    logic                err_q;
    logic [3:0][2:0]     cnt_q, cnt_d;
    logic [3:0][WW-1:0]  wcnt_q, wcnt_d;

    logic [3:0] elig;
    logic [1:0] win_d;
    logic [1:0] idx;
    logic       found;
    logic       accept;
    logic       acc_rd;
    logic       resp_ok;
    logic       resp_bad;
    logic [3:0] inc_v;
    logic [3:0] dec_v;

    // Eligibility: writes always, reads only below the outstanding limit.
    always_comb begin
        elig = '0;
        for (int i = 0; i < 4; i++) begin
            elig[i] = bus.p_req[i] && (bus.p_wr[i] || (cnt_q[i] < MAXC));
        end
    end

    // Round-robin search from rr_ptr; port 0 overrides when PRIO0 is set.
    always_comb begin
        win_d = 2'd0;
        found = 1'b0;
        idx   = 2'd0;
        for (int k = 0; k < 4; k++) begin
            idx = rr_ptr_q + 2'(k);
            if (!found && elig[idx]) begin
                win_d = idx;
                found = 1'b1;
            end
        end
        if (PRIO0 && elig[0]) begin
            win_d = 2'd0;
        end
    end

    // A grant being reset is discarded, so it is never accepted.
    assign accept   = (state_q == GRANT) && bus.req_ack && !reset;
    assign acc_rd   = accept && !req_wr_q;
    assign resp_ok  = bus.mem_valid && (cnt_q[bus.mem_id] != 3'd0);
    assign resp_bad = bus.mem_valid && (cnt_q[bus.mem_id] == 3'd0);

    // Per-port read accounting; an accept and a burst completion cancel out.
    always_comb begin
        cnt_d  = cnt_q;
        wcnt_d = wcnt_q;
        inc_v  = '0;
        dec_v  = '0;
        for (int i = 0; i < 4; i++) begin
            inc_v[i] = acc_rd && (grant_q == 2'(i));
            if (resp_ok && (bus.mem_id == 2'(i))) begin
                if (wcnt_q[i] == WLAST) begin
                    wcnt_d[i] = '0;
                    dec_v[i]  = 1'b1;
                end else begin
                    wcnt_d[i] = wcnt_q[i] + WW'(1);
                end
            end
            if (inc_v[i] && !dec_v[i]) begin
                cnt_d[i] = cnt_q[i] + 3'd1;
            end else if (!inc_v[i] && dec_v[i]) begin
                cnt_d[i] = cnt_q[i] - 3'd1;
            end
        end
    end

    // Arbitration FSM, read-return routing and status registers.
    always_ff @(posedge clkSYS) begin
        if (reset) begin
            state_q    <= IDLE;
            rr_ptr_q   <= 2'd0;
            grant_q    <= 2'd0;
            req_q      <= 1'b0;
            req_wr_q   <= 1'b0;
            req_addr_q <= '0;
            req_data_q <= '0;
            p_rvalid_q <= 4'd0;
            p_rdata_q  <= '0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
            wcnt_q     <= '0;
        end else begin
            cnt_q      <= cnt_d;
            wcnt_q     <= wcnt_d;
            p_rvalid_q <= bus.mem_valid ? 4'(4'b0001 << bus.mem_id) : 4'd0;
            if (bus.mem_valid) begin
                p_rdata_q <= bus.mem_data;
            end
            if (resp_bad) begin
                err_q <= 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    if (|elig) begin
                        state_q    <= GRANT;
                        grant_q    <= win_d;
                        req_q      <= 1'b1;
                        req_addr_q <= bus.p_addr[win_d];
                        req_data_q <= bus.p_data[win_d];
                        req_wr_q   <= bus.p_wr[win_d];
                    end
                end
                GRANT: begin
                    if (bus.req_ack) begin
                        state_q  <= IDLE;
                        req_q    <= 1'b0;
                        rr_ptr_q <= grant_q + 2'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.p_ack    = accept ? 4'(4'b0001 << grant_q) : 4'd0;
    assign bus.p_rvalid = p_rvalid_q;
    assign bus.p_rdata  = p_rdata_q;
    assign bus.req_addr = req_addr_q;
    assign bus.req_data = req_data_q;
    assign bus.req_id   = grant_q;
    assign bus.req      = req_q;
    assign bus.req_wr   = req_wr_q;
    assign bus.busy     = (state_q == GRANT);
    assign bus.err      = err_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: a behavioural model tracks the PRIO0=1 instance every
// cycle; directed sequences and a vector table cover the corner cases, and a
// second instance with PRIO0=0 is driven from the round-robin vector table.
module tb_sdram_arbiter;
    localparam int BURST = 8;
    localparam int MAXRD = 2;
    localparam bit PRIO  = 1'b1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sdram_arbiter_if #(.AN(24), .DN(16)) bus ();
    sdram_arbiter_if #(.AN(24), .DN(16)) bus_rr ();

    sdram_arbiter #(.AN(24), .DN(16), .BURST(BURST), .MAXRD(MAXRD), .PRIO0(1'b1)) u_dut (
        .clkSYS (clk),
        .reset  (rst),
        .bus    (bus)
    );

    sdram_arbiter #(.AN(24), .DN(16), .BURST(BURST), .MAXRD(MAXRD), .PRIO0(1'b0)) u_rr (
        .clkSYS (clk),
        .reset  (rst),
        .bus    (bus_rr)
    );

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model of the PRIO0=1 instance.
    bit          m_busy;
    int          m_gid;
    logic [23:0] m_addr;
    logic [15:0] m_data;
    bit          m_wr;
    int          m_rr;
    int          m_out[4];
    int          m_wc[4];
    logic [3:0]  m_rv;
    logic [15:0] m_rd;
    bit          m_err;
    logic [3:0]  exp_ack;

    bit rand_on = 1'b0;
    int q_ids[$];
    int wcount = 0;

    typedef struct {
        logic [3:0] preq;
        logic       ack;
        logic       exp_req;
        logic [1:0] exp_id;
        logic [3:0] exp_pack;
    } vec_t;
    vec_t vt[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0; m_gid = 0; m_addr = '0; m_data = '0; m_wr = 1'b0; m_rr = 0;
        m_rv = '0; m_rd = '0; m_err = 1'b0; exp_ack = '0;
        for (int i = 0; i < 4; i++) begin
            m_out[i] = 0;
            m_wc[i]  = 0;
        end
    endtask

    function automatic bit m_elig(input int i);
        return bus.p_req[i] && (bus.p_wr[i] || (m_out[i] < MAXRD));
    endfunction

    task automatic model_check();
        exp_ack = (m_busy && bus.req_ack && !rst) ? 4'(1 << m_gid) : 4'd0;
        chk("req", 32'(bus.req), 32'(m_busy));
        chk("busy", 32'(bus.busy), 32'(m_busy));
        if (m_busy) begin
            chk("req_id", 32'(bus.req_id), 32'(m_gid));
            chk("req_addr", 32'(bus.req_addr), 32'(m_addr));
            chk("req_data", 32'(bus.req_data), 32'(m_data));
            chk("req_wr", 32'(bus.req_wr), 32'(m_wr));
        end
        chk("p_ack", 32'(bus.p_ack), 32'(exp_ack));
        chk("p_rvalid", 32'(bus.p_rvalid), 32'(m_rv));
        if (m_rv != 4'd0) chk("p_rdata", 32'(bus.p_rdata), 32'(m_rd));
        chk("err", 32'(bus.err), 32'(m_err));
    endtask

    task automatic model_step();
        int inc_p;
        int w;
        int id;
        if (rst) begin
            model_reset();
            q_ids.delete();
            wcount = 0;
            return;
        end
        inc_p = -1;
        if (!m_busy) begin
            w = -1;
            if (PRIO && m_elig(0)) w = 0;
            else begin
                for (int k = 0; k < 4; k++) begin
                    if (w < 0 && m_elig((m_rr + k) % 4)) w = (m_rr + k) % 4;
                end
            end
            if (w >= 0) begin
                m_busy = 1'b1;
                m_gid  = w;
                m_addr = bus.p_addr[w];
                m_data = bus.p_data[w];
                m_wr   = bus.p_wr[w];
            end
        end else if (bus.req_ack) begin
            m_busy = 1'b0;
            m_rr   = (m_gid + 1) % 4;
            if (!m_wr) begin
                inc_p = m_gid;
                if (rand_on) q_ids.push_back(m_gid);
            end
        end
        m_rv = 4'd0;
        if (bus.mem_valid) begin
            id   = int'(bus.mem_id);
            m_rv = 4'(1 << id);
            m_rd = bus.mem_data;
            if (m_out[id] == 0) m_err = 1'b1;
            else begin
                m_wc[id]++;
                if (m_wc[id] == BURST) begin
                    m_wc[id] = 0;
                    m_out[id]--;
                end
            end
        end
        if (inc_p >= 0) m_out[inc_p]++;
    endtask

    task automatic half();
        @(negedge clk);
        model_check();
    endtask

    task automatic adv();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.p_req = 4'd0; bus.p_wr = 4'd0; bus.req_ack = 1'b0;
        bus.mem_valid = 1'b0; bus.mem_id = 2'd0; bus.mem_data = 16'd0;
    endtask

    task automatic drive_random();
        for (int i = 0; i < 4; i++) begin
            if (exp_ack[i] || (!bus.p_req[i] && $urandom_range(0, 3) == 0)) begin
                bus.p_req[i]  = exp_ack[i] ? 1'($urandom_range(0, 1)) : 1'b1;
                bus.p_addr[i] = 24'($urandom);
                bus.p_data[i] = 16'($urandom);
                bus.p_wr[i]   = 1'($urandom_range(0, 1));
            end
        end
        bus.req_ack = ($urandom_range(0, 2) != 0);
        if (q_ids.size() > 0 && $urandom_range(0, 1) == 1) begin
            bus.mem_valid = 1'b1;
            bus.mem_id    = 2'(q_ids[0]);
            bus.mem_data  = 16'($urandom);
            wcount++;
            if (wcount == BURST) begin
                wcount = 0;
                void'(q_ids.pop_front());
            end
        end else begin
            bus.mem_valid = 1'b0;
        end
    endtask

    initial begin
        int c0, c3, a1, a2, got;

        vt[0]  = '{4'b1111, 1'b1, 1'b0, 2'd0, 4'b0000};
        vt[1]  = '{4'b1111, 1'b1, 1'b1, 2'd0, 4'b0001};
        vt[2]  = '{4'b1111, 1'b1, 1'b0, 2'd0, 4'b0000};
        vt[3]  = '{4'b1111, 1'b1, 1'b1, 2'd1, 4'b0010};
        vt[4]  = '{4'b1111, 1'b1, 1'b0, 2'd0, 4'b0000};
        vt[5]  = '{4'b1111, 1'b1, 1'b1, 2'd2, 4'b0100};
        vt[6]  = '{4'b1111, 1'b1, 1'b0, 2'd0, 4'b0000};
        vt[7]  = '{4'b1111, 1'b1, 1'b1, 2'd3, 4'b1000};
        vt[8]  = '{4'b1111, 1'b1, 1'b0, 2'd0, 4'b0000};
        vt[9]  = '{4'b1111, 1'b1, 1'b1, 2'd0, 4'b0001};
        vt[10] = '{4'b1010, 1'b1, 1'b0, 2'd0, 4'b0000};
        vt[11] = '{4'b1010, 1'b1, 1'b1, 2'd1, 4'b0010};
        vt[12] = '{4'b1010, 1'b1, 1'b0, 2'd0, 4'b0000};
        vt[13] = '{4'b1010, 1'b1, 1'b1, 2'd3, 4'b1000};
        vt[14] = '{4'b0100, 1'b0, 1'b0, 2'd0, 4'b0000};
        vt[15] = '{4'b0100, 1'b0, 1'b1, 2'd2, 4'b0000};
        vt[16] = '{4'b0100, 1'b1, 1'b1, 2'd2, 4'b0100};
        vt[17] = '{4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000};

        model_reset();
        rst = 1'b1;
        idle_inputs();
        bus.p_addr = '0; bus.p_data = '0;
        bus_rr.p_req = 4'd0; bus_rr.p_wr = 4'b1111; bus_rr.req_ack = 1'b0;
        bus_rr.mem_valid = 1'b0; bus_rr.mem_id = 2'd0; bus_rr.mem_data = 16'd0;
        for (int i = 0; i < 4; i++) begin
            bus_rr.p_addr[i] = 24'(32'h100 + i);
            bus_rr.p_data[i] = 16'(32'hA000 + i);
        end
        half(); adv();
        half(); adv();
        rst = 1'b0;
        half();
        chk("rst_rr_req", 32'(bus_rr.req), 32'd0);
        chk("rst_rr_err", 32'(bus_rr.err), 32'd0);
        adv();

        // Single read on port 2 with a stalled controller.
        bus.p_req = 4'b0100; bus.p_wr = 4'd0; bus.p_addr[2] = 24'h001234; bus.p_data[2] = 16'h0;
        half(); chk("t1_req_c0", 32'(bus.req), 32'd0); adv();
        for (int c = 1; c <= 3; c++) begin
            half();
            chk("t1_req", 32'(bus.req), 32'd1);
            chk("t1_id", 32'(bus.req_id), 32'd2);
            chk("t1_wr", 32'(bus.req_wr), 32'd0);
            chk("t1_addr", 32'(bus.req_addr), 32'h001234);
            chk("t1_no_ack", 32'(bus.p_ack), 32'd0);
            adv();
        end
        bus.req_ack = 1'b1;
        half(); chk("t1_ack", 32'(bus.p_ack), 32'b0100); adv();
        bus.p_req = 4'd0; bus.req_ack = 1'b0;
        half(); chk("t1_req_drop", 32'(bus.req), 32'd0); adv();
        chk("t1_cnt_one", 32'(u_dut.cnt_q[2]), 32'd1);
        for (int i = 0; i <= 8; i++) begin
            bus.mem_valid = (i < 8);
            bus.mem_id    = 2'd2;
            bus.mem_data  = 16'(32'hD000 + i);
            half();
            if (i == 0) chk("t1_rv_latency", 32'(bus.p_rvalid), 32'd0);
            else begin
                chk("t1_rvalid", 32'(bus.p_rvalid), 32'b0100);
                chk("t1_rdata", 32'(bus.p_rdata), 32'hD000 + 32'(i) - 32'd1);
            end
            adv();
        end
        idle_inputs();
        chk("t1_cnt_done", 32'(u_dut.cnt_q[2]), 32'd0);

        // Round-robin table on the PRIO0=0 instance.
        for (int k = 0; k < 18; k++) begin
            bus_rr.p_req   = vt[k].preq;
            bus_rr.req_ack = vt[k].ack;
            half();
            chk("rr_req", 32'(bus_rr.req), 32'(vt[k].exp_req));
            chk("rr_pack", 32'(bus_rr.p_ack), 32'(vt[k].exp_pack));
            if (vt[k].exp_req) begin
                chk("rr_id", 32'(bus_rr.req_id), 32'(vt[k].exp_id));
                chk("rr_data", 32'(bus_rr.req_data), 32'hA000 + 32'(vt[k].exp_id));
            end
            adv();
        end
        bus_rr.p_req = 4'd0; bus_rr.req_ack = 1'b0;

        // Fixed priority of port 0 against port 3.
        bus.p_req = 4'b1001; bus.p_wr = 4'b1001; bus.req_ack = 1'b1;
        bus.p_data[0] = 16'h0A0A; bus.p_data[3] = 16'h3B3B;
        c0 = 0; c3 = 0;
        for (int c = 0; c < 12; c++) begin
            half();
            if (bus.p_ack == 4'b0001) c0++;
            if (bus.p_ack == 4'b1000) c3++;
            adv();
        end
        chk("prio_p0_wins", 32'(c0), 32'd6);
        chk("prio_p3_blocked", 32'(c3), 32'd0);
        bus.p_req = 4'b1000; c3 = 0;
        for (int c = 0; c < 6; c++) begin
            half();
            if (bus.p_ack == 4'b1000) c3++;
            adv();
        end
        chk("prio_p3_alone", 32'(c3), 32'd3);

        // Outstanding-read limit on port 1 while port 2 writes.
        bus.p_req = 4'b0110; bus.p_wr = 4'b0100; bus.p_addr[1] = 24'h111111;
        a1 = 0; a2 = 0;
        for (int c = 0; c < 16; c++) begin
            half();
            if (bus.p_ack[1]) a1++;
            if (bus.p_ack[2]) a2++;
            adv();
        end
        chk("maxrd_p1_reads", 32'(a1), 32'd2);
        chk("maxrd_p2_writes", 32'(a2), 32'd6);
        bus.p_req = 4'b0010; a1 = 0;
        for (int i = 0; i < 8; i++) begin
            bus.mem_valid = 1'b1; bus.mem_id = 2'd1; bus.mem_data = 16'(32'h1100 + i);
            half();
            if (bus.p_ack[1]) a1++;
            adv();
        end
        chk("maxrd_blocked", 32'(a1), 32'd0);
        bus.mem_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            half();
            if (bus.p_ack[1]) a1++;
            adv();
            if (a1 != 0) bus.p_req = 4'd0;
        end
        chk("maxrd_third_read", 32'(a1), 32'd1);
        idle_inputs();

        // Stray response on a port with no reads outstanding.
        half(); chk("t5_err_before", 32'(bus.err), 32'd0); adv();
        for (int i = 0; i <= 8; i++) begin
            bus.mem_valid = (i < 8); bus.mem_id = 2'd3; bus.mem_data = 16'(32'h3000 + i);
            half();
            if (i > 0) chk("t5_rvalid", 32'(bus.p_rvalid), 32'b1000);
            adv();
        end
        idle_inputs();
        for (int c = 0; c < 4; c++) begin
            half(); chk("t5_err_sticky", 32'(bus.err), 32'd1); adv();
        end

        // Reset while a grant waits for the controller.
        bus.p_req = 4'b0001; bus.p_wr = 4'b0001; bus.req_ack = 1'b0;
        got = 0;
        for (int k = 0; k < 6 && got == 0; k++) begin
            half();
            if (bus.req) got = 1;
            else adv();
        end
        chk("t6_granted", 32'(got), 32'd1);
        adv();
        rst = 1'b1;
        half(); chk("t6_no_ack", 32'(bus.p_ack), 32'd0); adv();
        rst = 1'b0; bus.p_req = 4'd0;
        half();
        chk("t6_req_low", 32'(bus.req), 32'd0);
        chk("t6_no_ack_after", 32'(bus.p_ack), 32'd0);
        chk("t6_err_clr", 32'(bus.err), 32'd0);
        chk("t6_cnt_clr", 32'(u_dut.cnt_q), 32'd0);
        chk("t6_rr_clr", 32'(u_dut.rr_ptr_q), 32'd0);
        adv();

        // Randomised traffic against the model.
        rand_on = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            drive_random();
            half();
            adv();
        end
        rand_on = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Four-port arbiter in the system clock domain that shares the single SDRAM controller request interface (address/data/id/req/req_wr/req_ack) between requesters such as CPU, PPU, APU and DMA. It tags each accepted request with the port number as its 2-bit id. It demultiplexes returned read data (mem_valid/mem_id/mem_data) back to the owning port. It tracks outstanding read bursts per port so that no port can flood the command FIFO.

## Interface
- AN, 24, address width
- DN, 16, data width
- BURST, 8, words returned per read request
- MAXRD, 2, max outstanding read requests per port (1..7)
- PRIO0, 1, 1: port 0 has fixed top priority; 0: pure round-robin

Ports:
- clkSYS  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- p_addr  in  4×AN  per-port request address
- p_data  in  4×DN  per-port write data
- p_req  in  4  per-port request, held until acknowledged
- p_wr  in  4  per-port write flag (0 = read)
- p_ack  out  4  one-cycle accept pulse per port
- p_rvalid  out  4  per-port read data valid
- p_rdata  out  DN  read data, shared by all ports
- req_addr  out  AN  to controller
- req_data  out  DN  to controller
- req_id  out  2  granted port number
- req  out  1  request to controller
- req_wr  out  1  write flag to controller
- req_ack  in  1  controller accepts when req && req_ack
- mem_data  in  DN  returned read word
- mem_id  in  2  id of returned word
- mem_valid  in  1  returned word valid
- busy  out  1  grant held (state GRANT)
- err  out  1  sticky: response received for a port with zero outstanding reads

## Operation
- FSM IDLE / GRANT.
- IDLE: select a winner among eligible ports. A port is eligible when p_req[i] && (p_wr[i] || cnt[i] < MAXRD). If any port is eligible, register the winner's addr/data/wr into the output registers, set req_id = winner, req = 1, and go to GRANT.
- Winner selection: if PRIO0 and port 0 is eligible, port 0 wins. Otherwise round-robin, searching from rr_ptr upward modulo 4.
- GRANT: outputs stay stable. On req_ack: p_ack[grant] = req_ack (combinational, same cycle), req drops next cycle, FSM returns to IDLE, and rr_ptr = grant+1 mod 4. Port 0 wins under PRIO0 also advance rr_ptr.
- Read accounting, per port:
  - cnt[i] (3 bit) increments on an accepted read.
  - wcnt[i] (log2 BURST bits) counts returned words for that id. When wcnt[i] reaches BURST−1 and a word arrives, wcnt[i] wraps to 0 and cnt[i] decrements.
  - Accepted read and burst completion in the same cycle: cnt unchanged.
- Response from a port with cnt==0: the word is still forwarded, cnt stays 0, wcnt is not advanced, and err is set.
- Response routing: p_rvalid[mem_id] <= mem_valid and p_rdata <= mem_data (registered). All other p_rvalid bits are 0.
- Requesters must keep p_req and payload stable until p_ack. A requester that drops p_req while in GRANT does not cancel the grant.

## Timing
- Reset values: req=0, req_addr=0, req_data=0, req_id=0, req_wr=0, p_ack=0, p_rvalid=0, p_rdata=0, busy=0, err=0, state IDLE, rr_ptr=0, all cnt/wcnt=0.
- Reset asserted in GRANT: req=0 on the next edge, the pending request is discarded, and no p_ack is issued.
- Request latency: p_req high in cycle 0 with the arbiter idle → req high in cycle 1. p_ack coincides with the req_ack cycle.
- Back-to-back: after an accept in cycle N, IDLE in N+1, next req in N+2. Peak throughput is one request per 2 cycles.
- Response latency: mem_valid in cycle N → p_rvalid in cycle N+1.
- Eligibility uses cnt values registered at the IDLE decision edge, so an eligibility change from a completing burst takes effect one cycle later.

## Test plan
- Single read, port 2, addr 0x001234: req in cycle 1 with req_id=2, req_wr=0; req_ack held low for 3 cycles then high → one p_ack[2] pulse; 8 words on mem_id=2 → 8 p_rvalid[2] pulses with data matching, each 1 cycle late; cnt[2] returns to 0.
- Round-robin, PRIO0=0, all four ports writing continuously, req_ack always 1 → grant order 0,1,2,3,0,…, one accept every 2 cycles.
- PRIO0=1, ports 0 and 3 requesting continuously → port 0 wins every arbitration; port 3 wins only when p_req[0] is low.
- MAXRD=2, port 1 issues 3 reads, no responses → third read not granted and port 2's writes proceed. After 8 words on id 1 → third read granted the next arbitration.
- 8 mem_valid words on id 3 with cnt[3]=0 → all forwarded to p_rvalid[3], err=1 and stays 1 until reset.
- Reset pulsed while in GRANT with req_ack=0 → req=0 next cycle, no p_ack, all counters 0, rr_ptr=0.
